// File: rtl/c17_pipe_array.sv
// LANES parallel C17 lanes behind a 2-stage valid/ready pipeline.
// Optional output toggle counter enabled by defining C17_TOGGLE_CNT_EN.
module c17_pipe_array #(
  parameter int unsigned LANES = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [5*LANES-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*LANES-1:0]   out_data,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     toggle_cnt
);

  localparam int unsigned IN_W  = 5 * LANES;
  localparam int unsigned OUT_W = 2 * LANES;
  localparam int unsigned PC_W  = $clog2(OUT_W + 1);

  logic             v1;
  logic [IN_W-1:0]  s1_data;
  logic [OUT_W-1:0] f_s1;
  logic             adv2;
  logic             in_xfer;

  // Per-lane C17 function on the S1 word: {g7,g6,g3,g2,g1} -> {g23,g22}
  for (genvar i = 0; i < int'(LANES); i++) begin : g_lane
    logic [4:0] w;
    logic       nand36;
    assign w               = s1_data[5*i +: 5];
    assign nand36          = ~(w[2] & w[3]);
    assign f_s1[2*i]       = (w[0] & w[2]) | (w[1] & nand36);
    assign f_s1[2*i+1]     = nand36 & (w[1] | w[4]);
  end

  // Combinational backpressure; out_valid is the S2 valid bit
  always_comb begin
    adv2     = v1 & (~out_valid | out_ready);
    in_ready = ~v1 | adv2;
    in_xfer  = in_valid & in_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      s1_data   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (in_xfer) begin
        s1_data <= in_data;
      end
      if (in_xfer) begin
        v1 <= 1'b1;
      end else if (adv2) begin
        v1 <= 1'b0;
      end
      if (adv2) begin
        out_data  <= f_s1;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef C17_TOGGLE_CNT_EN
  logic [OUT_W-1:0] last_out;
  logic [OUT_W-1:0] diff;
  logic [PC_W-1:0]  pc;
  logic [CNT_W:0]   sum;
  logic             out_xfer;

  // Toggle count of the leaving word against the previous one, one extra bit for saturation
  always_comb begin
    out_xfer = out_valid & out_ready;
    diff     = out_data ^ last_out;
    pc       = '0;
    for (int unsigned i = 0; i < OUT_W; i++) begin
      pc = pc + PC_W'(diff[i]);
    end
    sum = (CNT_W+1)'(toggle_cnt) + (CNT_W+1)'(pc);
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      toggle_cnt <= '0;
      last_out   <= '0;
    end else if (out_xfer) begin
      toggle_cnt <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
      last_out   <= out_data;
    end
  end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign toggle_cnt     = '0;
`endif

endmodule

// File: tb/tb_c17_pipe_array.sv
// Scoreboard bench for c17_pipe_array: a LANES=1 instance and a LANES=4/CNT_W=4 instance.
module tb_c17_pipe_array;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        rst1 = 1'b1, iv1 = 1'b0, ir1, ov1, or1 = 1'b0, clr1 = 1'b0;
  logic [4:0]  id1 = '0;
  logic [1:0]  od1;
  logic [15:0] tc1;

  logic        rst4 = 1'b1, iv4 = 1'b0, ir4, ov4, or4 = 1'b0, clr4 = 1'b0;
  logic [19:0] id4 = '0;
  logic [7:0]  od4;
  logic [3:0]  tc4;

  logic [1:0] q1[$];
  logic [7:0] q4[$];

  c17_pipe_array #(.LANES(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst1), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .cnt_clr(clr1), .toggle_cnt(tc1)
  );

  c17_pipe_array #(.LANES(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst4), .in_valid(iv4), .in_ready(ir4), .in_data(id4),
    .out_valid(ov4), .out_ready(or4), .out_data(od4), .cnt_clr(clr4), .toggle_cnt(tc4)
  );

  // Reference C17 as the classic six-NAND netlist
  function automatic logic [1:0] c17(input logic [4:0] x);
    logic n10, n11, n16, n19;
    n10 = ~(x[0] & x[2]);
    n11 = ~(x[2] & x[3]);
    n16 = ~(x[1] & n11);
    n19 = ~(n11 & x[4]);
    return {~(n16 & n19), ~(n10 & n16)};
  endfunction

  function automatic logic [7:0] c17x4(input logic [19:0] w);
    logic [7:0] r;
    for (int i = 0; i < 4; i++) r[2*i +: 2] = c17(w[5*i +: 5]);
    return r;
  endfunction

  // Scoreboards: push on input transfer, pop and compare on output transfer
  always @(negedge clk) begin
    if (!rst1) begin
      if (iv1 && ir1) q1.push_back(c17(id1));
      if (ov1 && or1) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL sb1_unexpected: got out %b with empty scoreboard", od1);
        end else begin
          logic [1:0] e;
          e = q1.pop_front();
          if (od1 !== e) begin
            errors++;
            $display("FAIL sb1_data: got %b expected %b", od1, e);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst4) begin
      if (iv4 && ir4) q4.push_back(c17x4(id4));
      if (ov4 && or4) begin
        checks++;
        if (q4.size() == 0) begin
          errors++;
          $display("FAIL sb4_unexpected: got out %h with empty scoreboard", od4);
        end else begin
          logic [7:0] e;
          e = q4.pop_front();
          if (od4 !== e) begin
            errors++;
            $display("FAIL sb4_data: got %h expected %h", od4, e);
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst1 = 1'b1; rst4 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst1 = 1'b0; rst4 = 1'b0;
    checks++;
    if (ov1 !== 1'b0 || od1 !== 2'b00 || ir1 !== 1'b1 || tc1 !== 16'd0) begin
      errors++;
      $display("FAIL reset1: got ov=%b od=%b ir=%b tc=%0d expected 0 0 1 0", ov1, od1, ir1, tc1);
    end
    checks++;
    if (ov4 !== 1'b0 || od4 !== 8'h00 || ir4 !== 1'b1 || tc4 !== 4'd0) begin
      errors++;
      $display("FAIL reset4: got ov=%b od=%h ir=%b tc=%0d expected 0 0 1 0", ov4, od4, ir4, tc4);
    end
  endtask

  task automatic test_exhaustive();
    for (int c = 0; c < 36; c++) begin
      logic exp_v;
      @(posedge clk);
      #1;
      iv1 = (c < 32);
      id1 = 5'(c);
      or1 = 1'b1;
      @(negedge clk);
      exp_v = (c >= 2) && (c < 34);
      checks++;
      if (ir1 !== 1'b1) begin
        errors++;
        $display("FAIL exh_in_ready c=%0d: got %b expected 1", c, ir1);
      end
      checks++;
      if (ov1 !== exp_v) begin
        errors++;
        $display("FAIL exh_latency c=%0d: got out_valid %b expected %b", c, ov1, exp_v);
      end
      if (c == 7) begin
        checks++;
        if (od1 !== 2'b01) begin
          errors++;
          $display("FAIL exh_00101: got %b expected 01", od1);
        end
      end
      if (c == 14) begin
        checks++;
        if (od1 !== 2'b00) begin
          errors++;
          $display("FAIL exh_01100: got %b expected 00", od1);
        end
      end
    end
    iv1 = 1'b0;
  endtask

  task automatic test_throughput();
    for (int c = 0; c < 12; c++) begin
      logic exp_v;
      @(posedge clk);
      #1;
      iv4 = (c < 8);
      id4 = 20'($urandom());
      or4 = 1'b1;
      @(negedge clk);
      exp_v = (c >= 2) && (c < 10);
      checks++;
      if (ir4 !== 1'b1) begin
        errors++;
        $display("FAIL thr_in_ready c=%0d: got %b expected 1", c, ir4);
      end
      checks++;
      if (ov4 !== exp_v) begin
        errors++;
        $display("FAIL thr_out_valid c=%0d: got %b expected %b", c, ov4, exp_v);
      end
    end
    iv4 = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [19:0] w [3];
    int idx = 0;
    int outs = 0;
    for (int i = 0; i < 3; i++) w[i] = 20'($urandom());
    for (int cyc = 0; cyc < 40 && !(idx == 3 && outs == 3); cyc++) begin
      @(posedge clk);
      #1;
      iv4 = (idx < 3);
      id4 = (idx < 3) ? w[idx] : 20'd0;
      or4 = (cyc >= 5);
      @(negedge clk);
      if (cyc >= 2 && cyc <= 4) begin
        checks++;
        if (ir4 !== 1'b0 || ov4 !== 1'b1 || od4 !== c17x4(w[0])) begin
          errors++;
          $display("FAIL bp_hold cyc=%0d: got ir=%b ov=%b od=%h expected 0 1 %h",
                   cyc, ir4, ov4, od4, c17x4(w[0]));
        end
      end
      if (iv4 && ir4) idx++;
      if (ov4 && or4) outs++;
    end
    iv4 = 1'b0;
    checks++;
    if (idx != 3 || outs != 3) begin
      errors++;
      $display("FAIL bp_count: got accepted=%0d emitted=%0d expected 3 3", idx, outs);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (q4.size() != 0 || ov4 !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: got pending=%0d ov=%b expected 0 0", q4.size(), ov4);
    end
  endtask

  task automatic test_reset_midstream();
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      iv4 = 1'b1;
      id4 = 20'($urandom());
      or4 = 1'b0;
    end
    @(posedge clk);
    #1;
    iv4 = 1'b0;
    rst4 = 1'b1;
    @(negedge clk);
    checks++;
    if (ov4 !== 1'b1 || ir4 !== 1'b0) begin
      errors++;
      $display("FAIL rst_pre: got ov=%b ir=%b expected 1 0", ov4, ir4);
    end
    @(posedge clk);
    #1;
    rst4 = 1'b0;
    q4.delete();
    checks++;
    if (ov4 !== 1'b0 || od4 !== 8'h00 || ir4 !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid: got ov=%b od=%h ir=%b expected 0 00 1", ov4, od4, ir4);
    end
    or4 = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (ov4 !== 1'b0) begin
        errors++;
        $display("FAIL rst_ghost c=%0d: got out_valid %b expected 0", c, ov4);
      end
    end
  endtask

  task automatic test_toggle();
    logic [19:0] word [6];
    logic [7:0]  exp_od [6];
    logic [3:0]  exp_cnt [6];
    logic        clr_s [6];
    word[0] = 20'h00000; exp_od[0] = 8'h00; clr_s[0] = 1'b0;
    word[1] = 20'hAD6B5; exp_od[1] = 8'hFF; clr_s[1] = 1'b0;
    word[2] = 20'h002B5; exp_od[2] = 8'h0F; clr_s[2] = 1'b0;
    word[3] = 20'hAD6B5; exp_od[3] = 8'hFF; clr_s[3] = 1'b0;
    word[4] = 20'h002B5; exp_od[4] = 8'h0F; clr_s[4] = 1'b1;
    word[5] = 20'hAD6B5; exp_od[5] = 8'hFF; clr_s[5] = 1'b0;
`ifdef C17_TOGGLE_CNT_EN
    exp_cnt[0] = 4'd0;  exp_cnt[1] = 4'd8; exp_cnt[2] = 4'd12;
    exp_cnt[3] = 4'd15; exp_cnt[4] = 4'd0; exp_cnt[5] = 4'd8;
`else
    for (int s = 0; s < 6; s++) exp_cnt[s] = 4'd0;
`endif
    for (int s = 0; s < 6; s++) begin
      logic got;
      @(posedge clk);
      #1;
      iv4 = 1'b1;
      id4 = word[s];
      or4 = 1'b1;
      clr4 = 1'b0;
      @(posedge clk);
      #1;
      iv4 = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
        @(negedge clk);
        if (ov4 === 1'b1) begin
          got = 1'b1;
          clr4 = clr_s[s];
          checks++;
          if (od4 !== exp_od[s]) begin
            errors++;
            $display("FAIL tog_data s=%0d: got %h expected %h", s, od4, exp_od[s]);
          end
        end else begin
          @(posedge clk);
        end
      end
      @(posedge clk);
      #1;
      clr4 = 1'b0;
      checks++;
      if (!got || tc4 !== exp_cnt[s]) begin
        errors++;
        $display("FAIL tog_cnt s=%0d: got emitted=%b cnt=%0d expected 1 %0d", s, got, tc4, exp_cnt[s]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_exhaustive();
    test_throughput();
    test_backpressure();
    test_reset_midstream();
    test_toggle();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1);
  end

endmodule
